// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - windowed register-file bus slave with programmable RDY wait states
// Optional write-lock on reg[0] bit0 enabled by defining BUS_RESPONDER_LOCK_EN.
module bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hC000,
    parameter int          ADDR_W      = 4,
    parameter int          WAIT_STATES = 1,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic        CLK,
    input  logic        nRES,
    input  logic [15:0] ABus,
    input  logic        RnW,
    input  logic        CYC,
    input  logic [7:0]  DB_in,
    output logic [7:0]  DB_out,
    output logic        DB_oe,
    output logic        RDY,
    output logic        HIT,
    output logic        OVR
);

    localparam int         NREG = 1 << ADDR_W;
    localparam logic [3:0] WS   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                oe_q, oe_d;
    logic [7:0]          dout_q, dout_d;
    logic                hit_q, hit_d;
    logic                ovr_q, ovr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                rnw_q, rnw_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          regs_q [NREG];

    logic                addr_hit;
    logic [ADDR_W-1:0]   addr_idx;
    logic                do_commit;
    logic [ADDR_W-1:0]   c_idx;
    logic                c_rnw;
    logic [7:0]          c_data;
    logic                wr_locked;
    logic                wr_en;

    assign addr_hit = (ABus[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
    assign addr_idx = ABus[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdy_d     = 1'b1;
        oe_d      = 1'b0;
        dout_d    = dout_q;
        hit_d     = hit_q;
        ovr_d     = ovr_q;
        idx_d     = idx_q;
        rnw_d     = rnw_q;
        wdata_d   = wdata_q;
        do_commit = 1'b0;
        c_idx     = idx_q;
        c_rnw     = rnw_q;
        c_data    = wdata_q;

        case (state_q)
            S_IDLE, S_DATA: begin
                if (CYC && addr_hit) begin
                    idx_d   = addr_idx;
                    rnw_d   = RnW;
                    wdata_d = DB_in;
                    hit_d   = 1'b1;
                    if (WS != 4'd0) begin
                        cnt_d   = WS;
                        rdy_d   = 1'b0;
                        state_d = S_WAIT;
                    end else begin
                        // Zero wait states: commit straight from the bus on the accepting edge.
                        state_d   = S_DATA;
                        do_commit = 1'b1;
                        c_idx     = addr_idx;
                        c_rnw     = RnW;
                        c_data    = DB_in;
                    end
                end else begin
                    if (CYC) begin
                        hit_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                rdy_d = 1'b0;
                if (CYC) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d   = S_DATA;
                    rdy_d     = 1'b1;
                    cnt_d     = 4'd0;
                    do_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_commit && c_rnw) begin
            oe_d   = 1'b1;
            dout_d = regs_q[c_idx];
        end
    end

`ifdef BUS_RESPONDER_LOCK_EN
    assign wr_locked = regs_q[0][0] && (c_idx != '0);
`else
    assign wr_locked = 1'b0;
`endif

    assign wr_en = do_commit && !c_rnw && !wr_locked;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdy_q   <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
            hit_q   <= 1'b0;
            ovr_q   <= 1'b0;
            idx_q   <= '0;
            rnw_q   <= 1'b1;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            hit_q   <= hit_d;
            ovr_q   <= ovr_d;
            idx_q   <= idx_d;
            rnw_q   <= rnw_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else if (wr_en) begin
            regs_q[c_idx] <= c_data;
        end
    end

    assign DB_out = dout_q;
    assign DB_oe  = oe_q;
    assign RDY    = rdy_q;
    assign HIT    = hit_q;
    assign OVR    = ovr_q;

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Register-file slave on the far side of the core's address bus.
- Samples the 16-bit address, R/W and write data on a cycle strobe, and decodes a fixed address window.
- On a hit, inserts programmable wait states by pulling RDY low, then either drives read data onto the data bus or commits write data.
- Serves as the bench-side and on-chip peripheral counterpart to the address/data bus outputs of the 6502 core.

Parameters:
- BASE_ADDR, 16'hC000, base of the decoded window; must be aligned to 2^ADDR_W.
- ADDR_W, 4, log2 of register count; window spans BASE_ADDR .. BASE_ADDR+2^ADDR_W-1.
- WAIT_STATES, 1, RDY-low cycles inserted per hit; legal range 0..15.
- RESET_VALUE, 8'h00, value loaded into every register on reset.

Ports:
- CLK  input  1  single system clock; all state changes on rising edge.
- nRES  input  1  asynchronous active-low reset.
- ABus  input  16  address from core.
- RnW  input  1  1 = read, 0 = write; sampled with ABus.
- CYC  input  1  one-cycle strobe: ABus/RnW/DB_in valid this cycle.
- DB_in  input  8  write data from core.
- DB_out  output  8  read data.
- DB_oe  output  1  1 = DB_out driven and valid.
- RDY  output  1  0 = core must stall.
- HIT  output  1  registered: last accepted strobe decoded inside window.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Reset (nRES=0, asynchronous):
  - state=IDLE, wait counter=0.
  - RDY=1, DB_oe=0, DB_out=8'h00, HIT=0, OVR=0.
  - All registers = RESET_VALUE.
- Reset mid-transaction: pending write discarded, pending read abandoned, outputs forced to reset values immediately.
- Decode: hit = (ABus[15:ADDR_W] == BASE_ADDR[15:ADDR_W]); index = ABus[ADDR_W-1:0].
- States: IDLE, WAIT, DATA.
- IDLE:
  - CYC=1 and hit: latch index, RnW and DB_in; HIT<=1.
  - If WAIT_STATES>0: counter<=WAIT_STATES, RDY<=0, go to WAIT. Otherwise go to DATA.
  - CYC=1 and miss: HIT<=0, stay IDLE, no other change.
  - CYC=0: stay IDLE.
- WAIT:
  - RDY=0. Counter decrements each cycle.
  - When counter reaches 1: go to DATA, RDY<=1.
- Transition into DATA (the clock edge that enters DATA):
  - Write: reg[index]<=latched data.
  - Read: DB_out<=reg[index], DB_oe<=1.
- DATA:
  - Lasts exactly one cycle, RDY=1.
  - Next edge: DB_oe<=0; DB_out holds its last value.
  - CYC=1 during DATA is accepted exactly as in IDLE (back-to-back transactions; no idle cycle is required).
  - Otherwise return to IDLE.
- Latency, strobe at cycle T:
  - WAIT state (RDY=0) during cycles T+1 .. T+WAIT_STATES.
  - DATA state (DB_oe=1 for reads) at cycle T+WAIT_STATES+1.
  - WAIT_STATES=0: DATA at T+1; RDY never drops.
- Write visibility: a read of the same index in the next transaction returns the new value.
- CYC=1 while in WAIT: strobe ignored, OVR<=1 (sticky until reset), transaction in progress unaffected.
- Window boundaries: BASE_ADDR and BASE_ADDR+2^ADDR_W-1 are hits; BASE_ADDR-1 and BASE_ADDR+2^ADDR_W are misses.

Optional Feature:
- Macro: BUS_RESPONDER_LOCK_EN.
- Defined:
  - reg[0] bit0 is a write-lock bit.
  - While it is 1, writes to indices 1..2^ADDR_W-1 are acknowledged with normal timing but not committed.
  - Writes to reg[0] are always committed.
  - Reads are unaffected.
- Undefined: reg[0] is an ordinary register with no lock function.

Test Plan:
- Reset, then read 16'hC003 with WAIT_STATES=1 -> RDY=0 at T+1; at T+2 DB_oe=1, DB_out=8'h00, RDY=1.
- Write 8'hA5 to 16'hC00F, then read 16'hC00F back-to-back (CYC asserted in the write's DATA cycle) -> read returns 8'hA5, HIT=1 for both.
- Strobe at 16'hBFFF and at 16'hC010 -> HIT=0, RDY stays 1, DB_oe stays 0, registers unchanged.
- WAIT_STATES=3: strobe at T, extra CYC at T+2 -> RDY=0 for T+1..T+3, DATA at T+4, OVR=1 and stays 1 until reset.
- Write to 16'hC002 with nRES pulsed low during WAIT -> RDY=1 and DB_oe=0 immediately; later read of 16'hC002 returns RESET_VALUE.
- BUS_RESPONDER_LOCK_EN defined: write 8'h01 to 16'hC000, then 8'h5A to 16'hC001 -> read of 16'hC001 returns RESET_VALUE. Undefined: same read returns 8'h5A.
